// File: rtl/bcd_countdown.sv
// Multi-digit BCD down-counter with preset, pause/resume and auto-reload.
// Emits a one-cycle done pulse when the count reaches zero.
module bcd_countdown #(
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_value,
    input  logic                  start,
    input  logic                  stop,
    input  logic                  tick,
    input  logic                  reload_en,
    output logic [4*DIGITS-1:0]   count,
    output logic                  running,
    output logic                  done
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        PAUSE,
        DONE
    } state_t;

    localparam logic [4*DIGITS-1:0] ONE = {{(4*DIGITS-1){1'b0}}, 1'b1};

    state_t              state;
    state_t              state_nx;
    logic [4*DIGITS-1:0] preset;
    logic [4*DIGITS-1:0] preset_nx;
    logic [4*DIGITS-1:0] count_nx;
    logic [4*DIGITS-1:0] clamped;
    logic [4*DIGITS-1:0] dec;
    logic                done_nx;
    logic                is_zero;
    logic                is_one;

    assign is_zero = (count == '0);
    assign is_one  = (count == ONE);
    assign running = (state == RUN);

    always_comb begin
        clamped = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (load_value[4*i +: 4] > 4'd9)
                clamped[4*i +: 4] = 4'd9;
            else
                clamped[4*i +: 4] = load_value[4*i +: 4];
        end
    end

    // Ripple borrow: zero digits become 9 until a nonzero digit absorbs it
    always_comb begin
        logic borrow;
        borrow = 1'b1;
        dec    = count;
        for (int i = 0; i < DIGITS; i++) begin
            if (borrow) begin
                if (count[4*i +: 4] == 4'd0) begin
                    dec[4*i +: 4] = 4'd9;
                end else begin
                    dec[4*i +: 4] = count[4*i +: 4] - 4'd1;
                    borrow        = 1'b0;
                end
            end
        end
    end

    always_comb begin
        state_nx  = state;
        count_nx  = count;
        preset_nx = preset;
        done_nx   = 1'b0;
        if (load) begin
            count_nx  = clamped;
            preset_nx = clamped;
            state_nx  = IDLE;
        end else begin
            unique case (state)
                RUN: begin
                    if (stop) begin
                        state_nx = PAUSE;
                    end else if (tick) begin
                        if (is_one) begin
                            done_nx = 1'b1;
                            if (reload_en && (preset != '0)) begin
                                count_nx = preset;
                            end else begin
                                count_nx = '0;
                                state_nx = DONE;
                            end
                        end else if (!is_zero) begin
                            count_nx = dec;
                        end
                    end
                end
                IDLE, PAUSE, DONE: begin
                    if (start && !stop && !is_zero)
                        state_nx = RUN;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            count  <= '0;
            preset <= '0;
            done   <= 1'b0;
        end else begin
            state  <= state_nx;
            count  <= count_nx;
            preset <= preset_nx;
            done   <= done_nx;
        end
    end

endmodule

// File: tb/tb_bcd_countdown.sv
// Directed scoreboard bench for bcd_countdown.
// Stimulus pushes expectations; a negedge monitor pops and compares.
module tb_bcd_countdown;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        load;
    logic [15:0] load_value;
    logic        start;
    logic        stop;
    logic        tick;
    logic        reload_en;
    logic [15:0] count;
    logic        running;
    logic        done;

    typedef struct {
        string       name;
        logic [15:0] count;
        logic        running;
        logic        done;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    bcd_countdown #(.DIGITS(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (load),
        .load_value (load_value),
        .start      (start),
        .stop       (stop),
        .tick       (tick),
        .reload_en  (reload_en),
        .count      (count),
        .running    (running),
        .done       (done)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            checks++;
            if (count !== e.count || running !== e.running || done !== e.done) begin
                errors++;
                $display("FAIL %s: got count=%h running=%b done=%b, want count=%h running=%b done=%b",
                         e.name, count, running, done, e.count, e.running, e.done);
            end
        end
    end

    task automatic exp(input string n, input logic [15:0] c,
                       input logic r, input logic d);
        exp_t e;
        e.name    = n;
        e.count   = c;
        e.running = r;
        e.done    = d;
        sb.push_back(e);
    endtask

    // Drive one cycle of inputs, then return just after the edge
    task automatic cyc(input logic ld, input logic [15:0] lv,
                       input logic st, input logic sp,
                       input logic tk, input logic rl);
        load       = ld;
        load_value = lv;
        start      = st;
        stop       = sp;
        tick       = tk;
        reload_en  = rl;
        @(posedge clk);
        #1;
        load  = 1'b0;
        start = 1'b0;
        stop  = 1'b0;
        tick  = 1'b0;
    endtask

    task automatic rst_pulse(input string n);
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        exp(n, 16'h0000, 1'b0, 1'b0);
        @(negedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n      = 1'b0;
        load       = 1'b0;
        load_value = '0;
        start      = 1'b0;
        stop       = 1'b0;
        tick       = 1'b0;
        reload_en  = 1'b0;
        #1;
        exp("reset", 16'h0000, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // load, start, single tick with borrow
        cyc(1, 16'h0100, 0, 0, 0, 0); exp("load_0100", 16'h0100, 0, 0);
        cyc(0, 16'h0000, 1, 0, 0, 0); exp("start_0100", 16'h0100, 1, 0);
        cyc(0, 16'h0000, 0, 0, 1, 0); exp("borrow_0099", 16'h0099, 1, 0);
        cyc(0, 16'h0000, 0, 0, 0, 0); exp("hold_no_tick", 16'h0099, 1, 0);

        // count to zero without reload
        cyc(1, 16'h0002, 0, 0, 0, 0); exp("load_0002", 16'h0002, 0, 0);
        cyc(0, 16'h0000, 1, 0, 0, 0); exp("start_0002", 16'h0002, 1, 0);
        cyc(0, 16'h0000, 0, 0, 1, 0); exp("tick_0001", 16'h0001, 1, 0);
        cyc(0, 16'h0000, 0, 0, 1, 0); exp("zero_done", 16'h0000, 0, 1);
        cyc(0, 16'h0000, 0, 0, 0, 0); exp("done_once", 16'h0000, 0, 0);
        cyc(0, 16'h0000, 1, 0, 0, 0); exp("start_at_zero", 16'h0000, 0, 0);
        cyc(0, 16'h0000, 0, 0, 1, 0); exp("tick_at_zero", 16'h0000, 0, 0);

        // auto-reload
        cyc(1, 16'h0003, 0, 0, 0, 1); exp("load_0003", 16'h0003, 0, 0);
        cyc(0, 16'h0000, 1, 0, 0, 1); exp("start_0003", 16'h0003, 1, 0);
        cyc(0, 16'h0000, 0, 0, 1, 1); exp("rl_tick_0002", 16'h0002, 1, 0);
        cyc(0, 16'h0000, 0, 0, 1, 1); exp("rl_tick_0001", 16'h0001, 1, 0);
        cyc(0, 16'h0000, 0, 0, 1, 1); exp("reload_0003", 16'h0003, 1, 1);
        cyc(0, 16'h0000, 0, 0, 0, 1); exp("reload_pulse_once", 16'h0003, 1, 0);

        // stop beats tick; resume
        cyc(1, 16'h0050, 0, 0, 0, 0); exp("load_0050", 16'h0050, 0, 0);
        cyc(0, 16'h0000, 1, 0, 0, 0); exp("start_0050", 16'h0050, 1, 0);
        cyc(0, 16'h0000, 0, 1, 1, 0); exp("stop_wins", 16'h0050, 0, 0);
        cyc(0, 16'h0000, 0, 0, 1, 0); exp("pause_hold", 16'h0050, 0, 0);
        cyc(0, 16'h0000, 1, 0, 0, 0); exp("resume", 16'h0050, 1, 0);
        cyc(0, 16'h0000, 0, 0, 1, 0); exp("tick_0049", 16'h0049, 1, 0);
        cyc(0, 16'h0000, 1, 1, 0, 0); exp("stop_over_start", 16'h0049, 0, 0);

        // clamping and load priority
        cyc(1, 16'h00F7, 0, 0, 0, 0); exp("clamp_0097", 16'h0097, 0, 0);
        cyc(0, 16'h0000, 1, 0, 0, 0); exp("start_0097", 16'h0097, 1, 0);
        cyc(1, 16'h0025, 0, 0, 1, 0); exp("load_wins", 16'h0025, 0, 0);
        cyc(1, 16'hFAFA, 0, 0, 0, 0); exp("clamp_9999", 16'h9999, 0, 0);
        cyc(0, 16'h0000, 1, 0, 0, 0); exp("start_9999", 16'h9999, 1, 0);
        cyc(0, 16'h0000, 0, 0, 1, 0); exp("tick_9998", 16'h9998, 1, 0);
        cyc(1, 16'h1000, 0, 0, 0, 0); exp("load_1000", 16'h1000, 0, 0);
        cyc(0, 16'h0000, 1, 0, 0, 0); exp("start_1000", 16'h1000, 1, 0);
        cyc(0, 16'h0000, 0, 0, 1, 0); exp("full_borrow", 16'h0999, 1, 0);

        // reset mid-count
        cyc(1, 16'h1235, 0, 0, 0, 0); exp("load_1235", 16'h1235, 0, 0);
        cyc(0, 16'h0000, 1, 0, 0, 0); exp("start_1235", 16'h1235, 1, 0);
        cyc(0, 16'h0000, 0, 0, 1, 0); exp("mid_1234", 16'h1234, 1, 0);
        rst_pulse("reset_mid");
        cyc(0, 16'h0000, 1, 0, 0, 0); exp("start_after_rst", 16'h0000, 0, 0);

        // reset during done pulse
        cyc(1, 16'h0001, 0, 0, 0, 0); exp("load_0001", 16'h0001, 0, 0);
        cyc(0, 16'h0000, 1, 0, 0, 0); exp("start_0001", 16'h0001, 1, 0);
        cyc(0, 16'h0000, 0, 0, 1, 0); exp("done_0001", 16'h0000, 0, 1);
        rst_pulse("reset_in_done");
        cyc(0, 16'h0000, 0, 0, 0, 0); exp("post_rst_idle", 16'h0000, 0, 0);

        for (int i = 0; i < 20 && sb.size() > 0; i++)
            @(posedge clk);
        if (sb.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain: got %0d pending, want 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/bcd_countdown.md
BCD_COUNTDOWN -- requirements
Module: bcd_countdown

Interface
REQ-001 SHALL have parameter DIGITS, default 4, giving the number of BCD digits (1..8).
REQ-002 SHALL have port clk  input  1  the single clock; all state changes occur on the rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port load  input  1  single-cycle strobe; captures load_value.
REQ-005 SHALL have port load_value  input  4*DIGITS  preset value; digit 0 is bits [3:0] and is least significant.
REQ-006 SHALL have port start  input  1  begin or resume counting.
REQ-007 SHALL have port stop  input  1  pause counting.
REQ-008 SHALL have port tick  input  1  single-cycle decrement strobe.
REQ-009 SHALL have port reload_en  input  1  when set, reaching zero reloads the preset and keeps running.
REQ-010 SHALL have port count  output  4*DIGITS  current BCD value, registered.
REQ-011 SHALL have port running  output  1  high in state RUN.
REQ-012 SHALL have port done  output  1  single-cycle pulse on reaching zero.

Function
REQ-013 SHALL implement states IDLE, RUN, PAUSE and DONE, with running = (state == RUN).
REQ-014 SHALL, on load in any state, set count and the internal preset register to load_value and enter IDLE on the next edge.
REQ-015 SHALL clamp any load_value digit above 9 to 9 in both count and the preset register.
REQ-016 SHALL give load priority over start, stop and tick in the same cycle.
REQ-017 SHALL, on start in IDLE, PAUSE or DONE with count != 0, enter RUN.
REQ-018 SHALL ignore start when count == 0; the state is unchanged and done stays low.
REQ-019 SHALL, on stop in RUN, enter PAUSE; stop SHALL win over tick in the same cycle, leaving count unchanged.
REQ-020 SHALL give stop priority when start and stop are asserted together.
REQ-021 SHALL decrement count by exactly 1 in decimal on each tick in RUN, with a latency of one edge.
REQ-022 SHALL perform per-digit decrement with borrow: a digit at 0 becomes 9 and borrows from the next digit; a digit at 1-9 decrements and the borrow chain stops.
REQ-023 SHALL hold count whenever tick is low or the state is not RUN.
REQ-024 SHALL, on a tick in RUN with count == 1:
- with reload_en = 0, set count to 0, enter DONE, and assert done for exactly the following cycle;
- with reload_en = 1, set count to the preset register, remain in RUN, and assert done for one cycle.
REQ-025 SHALL, when reload_en = 1 and the preset is 0, set count to 0, enter DONE and pulse done once.
REQ-026 SHALL never wrap from 0 to the all-9s value; a tick at count 0 is impossible in RUN and ignored elsewhere.
REQ-027 SHALL keep done low in every cycle except those given in REQ-024 and REQ-025.
REQ-028 SHALL keep every count digit within 0-9 at all times.
REQ-029 SHALL sample reload_en only on the edge where count reaches zero.

Reset
REQ-030 SHALL, while rst_n is low, force count to 0, the preset register to 0, state to IDLE, running to 0 and done to 0, independent of clk.
REQ-031 SHALL, on reset asserted mid-count or during a done pulse, clear the pulse immediately and discard the count.
REQ-032 SHALL ignore load, start, stop and tick until the first clk edge after rst_n deasserts.

Verification
REQ-033 SHALL cover: load 0x0100, start, one tick -> count 0x0099, running = 1.
REQ-034 SHALL cover: load 0x0002, start, reload_en = 0, two ticks -> count 0x0000, state DONE, done high for exactly one cycle, running = 0.
REQ-035 SHALL cover: load 0x0003, reload_en = 1, start, three ticks -> count returns to 0x0003, one done pulse, running stays 1.
REQ-036 SHALL cover: in RUN at 0x0050, stop and tick in the same cycle -> count 0x0050, state PAUSE; then start plus tick -> 0x0049.
REQ-037 SHALL cover: load 0x00F7 -> count 0x0097; load and tick in the same cycle in RUN -> load value wins and state becomes IDLE.
REQ-038 SHALL cover: rst_n pulsed low mid-count at 0x1234 -> count 0x0000, IDLE, done 0, and a later start is ignored.
